// File: rtl/ram_banked_2r1w.sv
// Parametrised two-read/one-write banked RAM with registered reads and a built-in clear sweep.
// Optional macro RAM_BANKED_FWD_EN selects write-first forwarding; default is read-first.
module ram_banked_2r1w #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int BANK_BITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              clr,
  output logic [DATA_W-1:0] d_out_a,
  output logic [DATA_W-1:0] d_out_b,
  output logic              valid_a,
  output logic              valid_b,
  output logic              busy
);

  localparam int ROW_W = ADDR_W - BANK_BITS;
  localparam int BANKS = 1 << BANK_BITS;
  localparam int ROWS  = 1 << ROW_W;
  localparam logic [ROW_W-1:0] LAST_ROW = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                        state;
  logic [ROW_W-1:0]              row_cnt;
  logic                          clearing;
  logic                          run_write;
  logic [BANK_BITS-1:0]          wr_bank;
  logic [BANK_BITS-1:0]          bank_a;
  logic [BANK_BITS-1:0]          bank_b;
  logic [ROW_W-1:0]              wr_row;
  logic [ROW_W-1:0]              row_a;
  logic [ROW_W-1:0]              row_b;
  logic [ROW_W-1:0]              mem_row;
  logic [DATA_W-1:0]             mem_data;
  logic [BANKS-1:0]              bank_we;
  logic [BANKS-1:0][DATA_W-1:0]  word_a;
  logic [BANKS-1:0][DATA_W-1:0]  word_b;
  logic                          fwd_a;
  logic                          fwd_b;

  assign wr_bank = wr_addr[ADDR_W-1 -: BANK_BITS];
  assign bank_a  = rd_addr_a[ADDR_W-1 -: BANK_BITS];
  assign bank_b  = rd_addr_b[ADDR_W-1 -: BANK_BITS];
  assign wr_row  = wr_addr[ROW_W-1:0];
  assign row_a   = rd_addr_a[ROW_W-1:0];
  assign row_b   = rd_addr_b[ROW_W-1:0];

  assign clearing = (state == CLEAR);
  assign busy     = clearing;

  // A clr in RUN takes priority over a concurrent write, which is dropped.
  assign run_write = (state == RUN) && wr && !clr;
  assign mem_row   = clearing ? row_cnt : wr_row;
  assign mem_data  = clearing ? '0 : d_in;

  always_comb begin
    bank_we = '0;
    if (clearing)
      bank_we = '1;
    else if (run_write)
      bank_we[wr_bank] = 1'b1;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
      if (bank_we[b])
        mem[mem_row] <= mem_data;
    end

    assign word_a[b] = mem[row_a];
    assign word_b[b] = mem[row_b];
  end

`ifdef RAM_BANKED_FWD_EN
  assign fwd_a = run_write && (wr_addr == rd_addr_a);
  assign fwd_b = run_write && (wr_addr == rd_addr_b);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // Sweep sequencer: CLEAR zeroes one row of every bank per cycle, then hands over to RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      row_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr) begin
            row_cnt <= '0;
          end else if (row_cnt == LAST_ROW) begin
            state   <= RUN;
            row_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + ROW_W'(1);
          end
        end
        RUN: begin
          if (clr) begin
            state   <= CLEAR;
            row_cnt <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          row_cnt <= '0;
        end
      endcase
    end
  end

  // Read ports hold their data when not enabled; reads during a sweep return zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out_a <= '0;
      d_out_b <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      valid_a <= rd_en_a;
      valid_b <= rd_en_b;
      if (rd_en_a)
        d_out_a <= clearing ? '0 : (fwd_a ? d_in : word_a[bank_a]);
      if (rd_en_b)
        d_out_b <= clearing ? '0 : (fwd_b ? d_in : word_b[bank_b]);
    end
  end

endmodule

// File: tb/tb_ram_banked_2r1w.sv
// Directed self-checking bench for ram_banked_2r1w (default and small parameter sets).
module tb_ram_banked_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [14:0] wr_addr;
  logic [15:0] d_in;
  logic        rd_en_a;
  logic [14:0] rd_addr_a;
  logic        rd_en_b;
  logic [14:0] rd_addr_b;
  logic        clr;
  logic [15:0] d_out_a;
  logic [15:0] d_out_b;
  logic        valid_a;
  logic        valid_b;
  logic        busy;

  logic        s_reset;
  logic [7:0]  s_d_out_a;
  logic [7:0]  s_d_out_b;
  logic        s_valid_a;
  logic        s_valid_b;
  logic        s_busy;

  int checks = 0;
  int errors = 0;
  int n;
  int ns;

  always #5 clk = ~clk;

  ram_banked_2r1w dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .clr(clr), .d_out_a(d_out_a), .d_out_b(d_out_b), .valid_a(valid_a), .valid_b(valid_b),
    .busy(busy)
  );

  ram_banked_2r1w #(.DATA_W(8), .ADDR_W(6), .BANK_BITS(1)) u_small (
    .clk(clk), .reset(s_reset), .wr(1'b0), .wr_addr(6'd0), .d_in(8'd0),
    .rd_en_a(1'b0), .rd_addr_a(6'd0), .rd_en_b(1'b0), .rd_addr_b(6'd0),
    .clr(1'b0), .d_out_a(s_d_out_a), .d_out_b(s_d_out_b), .valid_a(s_valid_a),
    .valid_b(s_valid_b), .busy(s_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [14:0] addr, input logic [15:0] data);
    wr      = 1'b1;
    wr_addr = addr;
    d_in    = data;
    step();
    wr      = 1'b0;
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 5000) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    reset = 1'b0; s_reset = 1'b0;
    wr = 1'b0; wr_addr = '0; d_in = '0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0; clr = 1'b0;
    #1;
    check_output("reset_d_out_a", 32'(d_out_a), 32'h0);
    check_output("reset_d_out_b", 32'(d_out_b), 32'h0);
    check_output("reset_valid_a", 32'(valid_a), 32'h0);
    check_output("reset_valid_b", 32'(valid_b), 32'h0);
    check_output("reset_busy", 32'(busy), 32'h1);
    check_output("reset_small_busy", 32'(s_busy), 32'h1);
    step(); step();

    // Both instances leave reset together; the small one finishes its sweep first.
    reset = 1'b1; s_reset = 1'b1;
    n = 0; ns = 0;
    while ((busy || s_busy) && n < 5000) begin
      step();
      n++;
      if (!s_busy && ns == 0) ns = n;
    end
    check_output("init_sweep_cycles", 32'(n), 32'd4096);
    check_output("small_sweep_cycles", 32'(ns), 32'd32);

    rd_en_a = 1'b1; rd_addr_a = 15'h0000;
    rd_en_b = 1'b1; rd_addr_b = 15'h3FFF;
    step();
    check_output("rd_0000", 32'(d_out_a), 32'h0);
    check_output("rd_0000_valid", 32'(valid_a), 32'h1);
    check_output("rd_3fff", 32'(d_out_b), 32'h0);
    check_output("rd_3fff_valid", 32'(valid_b), 32'h1);
    rd_addr_a = 15'h7FFF; rd_en_b = 1'b0;
    step();
    check_output("rd_7fff", 32'(d_out_a), 32'h0);
    check_output("rd_7fff_valid", 32'(valid_a), 32'h1);
    check_output("valid_b_drop", 32'(valid_b), 32'h0);
    rd_en_a = 1'b0;

    write_word(15'h0005, 16'h1111);
    write_word(15'h7005, 16'hBEEF);
    rd_en_a = 1'b1; rd_addr_a = 15'h0005;
    rd_en_b = 1'b1; rd_addr_b = 15'h7005;
    step();
    check_output("bank_a_0005", 32'(d_out_a), 32'h1111);
    check_output("bank_b_7005", 32'(d_out_b), 32'hBEEF);
    rd_addr_a = 15'h7005;
    step();
    check_output("same_addr_a", 32'(d_out_a), 32'hBEEF);
    check_output("same_addr_b", 32'(d_out_b), 32'hBEEF);
    rd_en_a = 1'b0; rd_en_b = 1'b0;

    write_word(15'h1234, 16'h0001);
    wr = 1'b1; wr_addr = 15'h1234; d_in = 16'hA5A5;
    rd_en_a = 1'b1; rd_addr_a = 15'h1234;
    step();
    wr = 1'b0;
`ifdef RAM_BANKED_FWD_EN
    check_output("same_cycle_rw", 32'(d_out_a), 32'hA5A5);
`else
    check_output("same_cycle_rw", 32'(d_out_a), 32'h0001);
`endif
    step();
    check_output("rw_next_read", 32'(d_out_a), 32'hA5A5);

    rd_addr_a = 15'h0005;
    step();
    check_output("hold_first", 32'(d_out_a), 32'h1111);
    rd_en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("hold_data", 32'(d_out_a), 32'h1111);
      check_output("hold_valid", 32'(valid_a), 32'h0);
    end

    // clr wins over the concurrent write; reads and writes during the sweep are checked.
    wr = 1'b1; wr_addr = 15'h0010; d_in = 16'hFFFF; clr = 1'b1;
    step();
    wr = 1'b0; clr = 1'b0;
    check_output("clr_busy", 32'(busy), 32'h1);
    rd_en_a = 1'b1; rd_addr_a = 15'h1234;
    step();
    check_output("clear_read_data", 32'(d_out_a), 32'h0);
    check_output("clear_read_valid", 32'(valid_a), 32'h1);
    rd_en_a = 1'b0;
    wr = 1'b1; wr_addr = 15'h0000; d_in = 16'h5555;
    step();
    wr = 1'b0;
    n = 2;
    while (busy && n < 5000) begin
      step();
      n++;
    end
    check_output("clr_sweep_cycles", 32'(n), 32'd4096);
    check_output("hold_through_clear", 32'(d_out_b), 32'hBEEF);
    rd_en_a = 1'b1; rd_addr_a = 15'h0005;
    step();
    check_output("after_clr_0005", 32'(d_out_a), 32'h0);
    rd_addr_a = 15'h0000;
    step();
    check_output("clear_wr_ignored", 32'(d_out_a), 32'h0);
    rd_addr_a = 15'h0010;
    step();
    check_output("clr_wr_dropped", 32'(d_out_a), 32'h0);

    // Asynchronous reset in the middle of a sweep while port A is reading.
    clr = 1'b1;
    step();
    clr = 1'b0;
    rd_addr_a = 15'h1234;
    for (int i = 0; i < 100; i++) step();
    check_output("midsweep_valid_a", 32'(valid_a), 32'h1);
    check_output("midsweep_hold_b", 32'(d_out_b), 32'hBEEF);
    reset = 1'b0;
    #1;
    check_output("async_d_out_b", 32'(d_out_b), 32'h0);
    check_output("async_valid_a", 32'(valid_a), 32'h0);
    check_output("async_busy", 32'(busy), 32'h1);
    rd_en_a = 1'b0;
    step(); step();
    reset = 1'b1;
    count_busy(n);
    check_output("reset_sweep_cycles", 32'(n), 32'd4096);
    rd_en_a = 1'b1; rd_addr_a = 15'h7005;
    step();
    check_output("after_reset_7005", 32'(d_out_a), 32'h0);
    check_output("after_reset_valid", 32'(valid_a), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_banked_2r1w.md
# ram_banked_2r1w

Parametrised two-read/one-write banked RAM. It is the successor to the fixed 32K×16 banked RAM, with configurable data width, address width and bank count. Reads are registered with valid flags and read enables. A built-in clear engine zeroes every word after reset or on request. It sits between the CPU datapath and the register/data memory address space wherever a dual-read, single-write store is needed.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 15, word address width; depth = 2^ADDR_W
- BANK_BITS, 3, number of bank-select MSBs; banks = 2^BANK_BITS; rows per bank = 2^(ADDR_W-BANK_BITS)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- wr  in  1  write enable
- wr_addr  in  ADDR_W  write address; MSBs select bank, LSBs select row
- d_in  in  DATA_W  write data
- rd_en_a  in  1  read enable, port A
- rd_addr_a  in  ADDR_W  read address, port A
- rd_en_b  in  1  read enable, port B
- rd_addr_b  in  ADDR_W  read address, port B
- clr  in  1  single-cycle request to re-run the clear sweep
- d_out_a  out  DATA_W  registered read data, port A
- d_out_b  out  DATA_W  registered read data, port B
- valid_a  out  1  d_out_a holds data from a read issued the previous cycle
- valid_b  out  1  d_out_b holds data from a read issued the previous cycle
- busy  out  1  clear sweep in progress

## Operation
- Storage is 2^BANK_BITS independent banks.
  - Write decode: wr_addr[ADDR_W-1 -: BANK_BITS] enables exactly one bank. No bank is written when wr=0.
  - Each read port muxes its own bank by its own address MSBs. Ports A and B never conflict, including on the same address.
- FSM states: CLEAR, RUN.
  - Reset assertion forces CLEAR with row counter 0.
  - CLEAR: every cycle, writes 0 to the current row in all banks in parallel, then increments the row counter.
  - CLEAR → RUN: on the cycle the counter reaches the last row (2^(ADDR_W-BANK_BITS)-1), after that row is written.
  - RUN → CLEAR: clr=1, counter reset to 0.
  - clr during CLEAR: restarts the counter at 0.
- During CLEAR:
  - wr is ignored.
  - rd_en_x is still honoured; the read returns 0 with valid_x=1.
  - busy=1.
- Reads in RUN: d_out_x updates only when rd_en_x=1. It holds its last value when rd_en_x=0. valid_x equals rd_en_x delayed one cycle.
- Write/read same address, same cycle: behaviour is set by the Configuration section.

## Timing
- Reset values:
  - d_out_a = d_out_b = 0
  - valid_a = valid_b = 0
  - busy = 1
  - FSM = CLEAR, row counter = 0
  - Array contents are undefined until the sweep completes.
- Clear duration: exactly 2^(ADDR_W-BANK_BITS) cycles after reset deassertion or after the clr cycle.
  - busy falls on the edge following the last row write.
  - Default: 4096 cycles.
- Read latency: 1 cycle. Address and enable sampled at edge N; data and valid presented after edge N.
- Write latency: 1 cycle. Data written at edge N is readable by a read issued at edge N+1.
- Reset asserted mid-sweep or mid-read:
  - Outputs return to reset values immediately (asynchronously).
  - The sweep restarts from row 0 on release.
- clr and wr in the same RUN cycle: clr wins. The write is dropped and the sweep starts.

## Configuration
- RAM_BANKED_FWD_EN defined: a same-cycle wr and rd_en_x to an equal address returns d_in on d_out_x (write-first forwarding, per port).
- RAM_BANKED_FWD_EN undefined: the read returns the pre-write contents (read-first). The new value is visible from the next cycle.
- Forwarding never applies during CLEAR; reads return 0 there.

## Test plan
- Reset, then release with defaults:
  - busy=1 for 4096 cycles, then 0.
  - Reads of 0x0000, 0x3FFF and 0x7FFF all return 0x0000 with valid=1 one cycle later.
- Bank independence:
  - Write 0x1111 to 0x0005 and 0xBEEF to 0x7005.
  - Read A=0x0005, B=0x7005 in the same cycle → d_out_a=0x1111, d_out_b=0xBEEF.
- Same-cycle write 0xA5A5 to 0x1234 with rd_a=0x1234, where the old value is 0x0001:
  - FWD_EN defined → d_out_a=0xA5A5.
  - FWD_EN undefined → d_out_a=0x0001, then 0xA5A5 on the next read.
- Hold behaviour: read 0x0005 (0x1111), then rd_en_a=0 for 3 cycles → d_out_a stays 0x1111, valid_a=0.
- clr in RUN with concurrent wr of 0xFFFF to 0x0010:
  - Write dropped; busy=1 for 4096 cycles.
  - Then read 0x0005 → 0x0000.
- Reset asserted at sweep row 100:
  - Outputs zero immediately.
  - After release, busy lasts a full 4096 cycles.
  - Parameter variant DATA_W=8, ADDR_W=6, BANK_BITS=1: sweep lasts 32 cycles.
